// File: rtl/mips16_pkg.sv
// mips16_pkg -- shared sizing defaults for the MIPS16 register file slice.
//   DEFAULT_DATA_W : register data width
//   DEFAULT_ADDR_W : register address width
//   DEFAULT_NREG   : register count, 2**DEFAULT_ADDR_W
package mips16_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned DEFAULT_NREG   = 1 << DEFAULT_ADDR_W;

endpackage : mips16_pkg

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- one pending bit per register, tracking in-flight writes.
//   clk, rst_n         : clock, asynchronous active-low reset
//   set_en, set_addr   : reserve a destination register (bit set next edge)
//   clr_en, clr_addr   : write-back completion (bit cleared next edge)
//   pending[NREG-1:0]  : current pending bits
// A set and a clear on the same register in one cycle leaves the bit set:
// the new producer owns the register.
module reg_scoreboard
    import mips16_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NREG   = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [NREG-1:0]   pending
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;

    // Clear applied first, then set, so set wins on a same-register collision.
    always_comb begin
        w_pending_nxt = r_pending;
        if (clr_en) begin
            w_pending_nxt[clr_addr] = 1'b0;
        end
        if (set_en) begin
            w_pending_nxt[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign pending = r_pending;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// reg_file_sb -- 2-read/1-write register file with write-back bypass and a
// pending-write scoreboard for issue-time hazard detection.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : write-back port (register 0 is never written)
//   rd_addr1/2            : source register addresses
//   rd_data1/2            : combinational source operands (with bypass)
//   iss_valid/iss_addr    : reserve a destination register at issue
//   busy1/2               : unresolved pending write on rd_addr1/2
//   stall                 : busy1 | busy2
module reg_file_sb
    import mips16_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              stall
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   w_pending;
    logic              w_wr_fire;
    logic              w_wr_live;
    logic              w_iss_accept;
    logic              w_hit1;
    logic              w_hit2;

    // Writes to r0 are dropped; during reset the write port is dead, so the
    // bypass is also suppressed and reads stay at zero.
    assign w_wr_fire = wr_en & (wr_addr != '0);
    assign w_wr_live = w_wr_fire & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign w_hit1 = w_wr_live & (wr_addr == rd_addr1);
    assign w_hit2 = w_wr_live & (wr_addr == rd_addr2);

    always_comb begin
        rd_data1 = '0;
        if (rd_addr1 != '0) begin
            rd_data1 = w_hit1 ? wr_data : r_regs[rd_addr1];
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (rd_addr2 != '0) begin
            rd_data2 = w_hit2 ? wr_data : r_regs[rd_addr2];
        end
    end

    // A write-back landing this cycle resolves the hazard it was pending on.
    // pending[0] can never set, so address 0 is never busy.
    assign busy1 = w_pending[rd_addr1] & ~w_hit1;
    assign busy2 = w_pending[rd_addr2] & ~w_hit2;
    assign stall = busy1 | busy2;

    // stall depends only on read addresses, pending bits and the write port,
    // so gating the issue with it forms no loop.
    assign w_iss_accept = iss_valid & ~stall & (iss_addr != '0);

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (w_iss_accept),
        .set_addr (iss_addr),
        .clr_en   (w_wr_fire),
        .clr_addr (wr_addr),
        .pending  (w_pending)
    );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        busy1;
    logic        busy2;
    logic        stall;

    int checks = 0;
    int passes = 0;

    // Reference model: architectural register values and outstanding writes.
    logic [15:0] m_regs [NR];
    bit          m_pend [NR];

    always #5 clk = ~clk;

    reg_file_sb #(
        .DATA_W (16),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy1     (busy1),
        .busy2     (busy2),
        .stall     (stall)
    );

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 16'h0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [15:0] exp_rd(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 16'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!rst_n) return 1'b0;
        return m_pend[a] && !(wr_en && wr_addr == a && a != 5'd0);
    endfunction

    function automatic logic exp_stall();
        return exp_busy(rd_addr1) || exp_busy(rd_addr2);
    endfunction

    // Advance one clock, applying the architectural effect of the inputs.
    task automatic tick();
        bit acc;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            acc = iss_valid && !exp_stall() && iss_addr != 5'd0;
            if (wr_en && wr_addr != 5'd0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (acc) m_pend[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = 16'h0;
        iss_valid = 1'b0;
        iss_addr  = 5'd0;
        rd_addr1  = 5'd0;
        rd_addr2  = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h1234;
        iss_valid = 1'b1; iss_addr = 5'd5;
        rd_addr1 = 5'd3; rd_addr2 = 5'd5;
        tick();
        tick();
        #1;
        checks++; if (rd_data1 !== 16'h0) $display("FAIL reset_rd1 got %h exp 0000", rd_data1); else passes++;
        checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 got %b exp 0", busy2); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passes++;
        // Release with a write and an issue already presented.
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 16'hAAAA;
        iss_valid = 1'b1; iss_addr = 5'd6;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        tick();
        idle();
        rd_addr1 = 5'd2; rd_addr2 = 5'd6;
        #1;
        checks++; if (rd_data1 !== 16'hAAAA) $display("FAIL release_write got %h exp aaaa", rd_data1); else passes++;
        checks++; if (busy2 !== 1'b1) $display("FAIL release_issue got %b exp 1", busy2); else passes++;
        checks++; if (stall !== 1'b1) $display("FAIL release_stall got %b exp 1", stall); else passes++;
        idle();
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 16'h0;
        tick();
        idle();
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h1234;
        tick();
        idle();
        rd_addr1 = 5'd5;
        #1;
        checks++; if (rd_data1 !== 16'h1234) $display("FAIL wr_rd_data got %h exp 1234", rd_data1); else passes++;
        checks++; if (busy1 !== 1'b0) $display("FAIL wr_rd_busy got %b exp 0", busy1); else passes++;
        tick();
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 16'hBEEF;
        rd_addr2 = 5'd7;
        #1;
        checks++; if (rd_data2 !== 16'hBEEF) $display("FAIL bypass_rd2 got %h exp beef", rd_data2); else passes++;
        tick();
        idle();
    endtask

    task automatic test_r0();
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hFFFF;
        iss_valid = 1'b1; iss_addr = 5'd0;
        #1;
        checks++; if (rd_data1 !== 16'h0) $display("FAIL r0_nobypass got %h exp 0000", rd_data1); else passes++;
        tick();
        idle();
        #1;
        checks++; if (rd_data1 !== 16'h0) $display("FAIL r0_read got %h exp 0000", rd_data1); else passes++;
        checks++; if (busy1 !== 1'b0) $display("FAIL r0_busy got %b exp 0", busy1); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL r0_stall got %b exp 0", stall); else passes++;
    endtask

    task automatic test_hazard();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        idle();
        rd_addr1 = 5'd3;
        // An issue presented while stalled must be dropped.
        iss_valid = 1'b1; iss_addr = 5'd8;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL hazard_stall got %b exp 1", stall); else passes++;
        checks++; if (busy1 !== 1'b1) $display("FAIL hazard_busy got %b exp 1", busy1); else passes++;
        tick();
        iss_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h0042;
        #1;
        checks++; if (busy1 !== 1'b0) $display("FAIL hazard_resolve got %b exp 0", busy1); else passes++;
        checks++; if (rd_data1 !== 16'h0042) $display("FAIL hazard_data got %h exp 0042", rd_data1); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL hazard_unstall got %b exp 0", stall); else passes++;
        tick();
        idle();
        rd_addr1 = 5'd3; rd_addr2 = 5'd8;
        #1;
        checks++; if (busy1 !== 1'b0) $display("FAIL hazard_cleared got %b exp 0", busy1); else passes++;
        checks++; if (busy2 !== 1'b0) $display("FAIL stalled_issue_dropped got %b exp 0", busy2); else passes++;
    endtask

    task automatic test_collision();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd4;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 16'h0011;
        iss_valid = 1'b1; iss_addr = 5'd4;
        tick();
        idle();
        rd_addr1 = 5'd4;
        #1;
        checks++; if (busy1 !== 1'b1) $display("FAIL collision_set_wins got %b exp 1", busy1); else passes++;
        // Write r4 and issue r10 together: both must take effect.
        rd_addr1 = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 16'h0022;
        iss_valid = 1'b1; iss_addr = 5'd10;
        tick();
        idle();
        rd_addr1 = 5'd4; rd_addr2 = 5'd10;
        #1;
        checks++; if (busy1 !== 1'b0) $display("FAIL split_clear got %b exp 0", busy1); else passes++;
        checks++; if (busy2 !== 1'b1) $display("FAIL split_set got %b exp 1", busy2); else passes++;
        checks++; if (rd_data1 !== 16'h0022) $display("FAIL split_data got %h exp 0022", rd_data1); else passes++;
        idle();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 16'h0;
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [15:0] e1, e2;
        logic        eb1, eb2, es;
        for (int n = 0; n < 400; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            iss_valid = 1'($urandom_range(0, 1));
            iss_addr  = 5'($urandom_range(0, 7));
            rd_addr1  = 5'($urandom_range(0, 7));
            rd_addr2  = 5'($urandom_range(0, 7));
            #1;
            e1 = exp_rd(rd_addr1);
            e2 = exp_rd(rd_addr2);
            eb1 = exp_busy(rd_addr1);
            eb2 = exp_busy(rd_addr2);
            es = exp_stall();
            checks++; if (rd_data1 !== e1) $display("FAIL rand_rd1 n=%0d got %h exp %h", n, rd_data1, e1); else passes++;
            checks++; if (rd_data2 !== e2) $display("FAIL rand_rd2 n=%0d got %h exp %h", n, rd_data2, e2); else passes++;
            checks++; if (busy1 !== eb1) $display("FAIL rand_busy1 n=%0d got %b exp %b", n, busy1, eb1); else passes++;
            checks++; if (busy2 !== eb2) $display("FAIL rand_busy2 n=%0d got %b exp %b", n, busy2, eb2); else passes++;
            checks++; if (stall !== es) $display("FAIL rand_stall n=%0d got %b exp %b", n, stall, es); else passes++;
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midop();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd1;
        tick();
        iss_addr = 5'd2;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'h5555;
        tick();
        idle();
        rd_addr1 = 5'd1; rd_addr2 = 5'd9;
        #1;
        checks++; if (busy1 !== 1'b1) $display("FAIL midop_pending got %b exp 1", busy1); else passes++;
        checks++; if (rd_data2 !== 16'h5555) $display("FAIL midop_data got %h exp 5555", rd_data2); else passes++;
        #1;
        rst_n = 1'b0;
        model_clear();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'h7777;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL midop_stall got %b exp 0", stall); else passes++;
        checks++; if (busy1 !== 1'b0) $display("FAIL midop_busy1 got %b exp 0", busy1); else passes++;
        checks++; if (rd_data2 !== 16'h0) $display("FAIL midop_rd2 got %h exp 0000", rd_data2); else passes++;
        tick();
        idle();
        rst_n = 1'b1;
        rd_addr1 = 5'd2; rd_addr2 = 5'd9;
        #1;
        checks++; if (busy1 !== 1'b0) $display("FAIL postreset_busy got %b exp 0", busy1); else passes++;
        checks++; if (rd_data2 !== 16'h0) $display("FAIL postreset_rd2 got %h exp 0000", rd_data2); else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_hazard();
        test_collision();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width; NREG = 2**ADDR_W = 32 registers.
REQ-003 Clocking: one clock. Reset is asynchronous and active-low.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 wr_en  input  1  SHALL be the write-back enable.
REQ-007 wr_addr  input  ADDR_W  SHALL be the destination register, driven by the rt/rd destination-select mux.
REQ-008 wr_data  input  DATA_W  SHALL be the write-back data.
REQ-009 rd_addr1, rd_addr2  input  ADDR_W each  SHALL be the source register addresses.
REQ-010 rd_data1, rd_data2  output  DATA_W each  SHALL be the source operand values.
REQ-011 iss_valid  input  1  SHALL request reservation of a destination register at issue.
REQ-012 iss_addr  input  ADDR_W  SHALL be the destination register being reserved.
REQ-013 busy1, busy2  output  1 each  SHALL flag an unresolved pending write on rd_addr1 and rd_addr2.
REQ-014 stall  output  1  SHALL equal busy1 | busy2.

Function
REQ-015 Write: on clk rise with wr_en=1 and wr_addr!=0, the addressed register SHALL take wr_data.
REQ-016 Register 0 SHALL never be written, and reads of address 0 SHALL return 0 with busy=0.
REQ-017 Reads SHALL be combinational with zero-cycle latency.
REQ-018 Bypass: when wr_en=1, wr_addr==rd_addrN and wr_addr!=0, rd_dataN SHALL equal wr_data in the same cycle.
REQ-019 Scoreboard: the module SHALL hold one pending bit per register.
REQ-020 Setting a pending bit: an issue is accepted when iss_valid=1, stall=0 and iss_addr!=0; the bit for iss_addr SHALL set on the next clk rise.
REQ-021 Clearing a pending bit: wr_en=1 with wr_addr!=0 SHALL clear the bit for wr_addr on the next clk rise.
REQ-022 When an accepted issue and a write target the same register in the same cycle, set SHALL win, so the bit stays 1 for the new producer.
REQ-023 When an accepted issue and a write target different registers in the same cycle, both updates SHALL occur.
REQ-024 busyN SHALL be pending[rd_addrN] & ~(wr_en & wr_addr==rd_addrN), so a same-cycle write-back resolves the hazard.
REQ-025 iss_valid with stall=1 SHALL be ignored: no pending bit changes.
REQ-026 No path from iss_valid or iss_addr to stall SHALL exist; there is no combinational loop.

Reset
REQ-027 While rst_n=0, all registers and all pending bits SHALL be 0, independent of clk.
REQ-028 Outputs during reset SHALL be: rd_data1/2 = 0 (no bypass, since writes are ignored), busy1/2 = 0, stall = 0.
REQ-029 Writes and issues in the cycle of reset release SHALL take effect on the first clk rise with rst_n=1.
REQ-030 Reset asserted mid-operation SHALL discard all pending reservations.

Structure
REQ-031 DATA_W, ADDR_W and NREG defaults SHALL live in shared package mips16_pkg.
REQ-032 The pending-bit logic SHALL be a sub-module, reg_scoreboard, with ports clk, rst_n, set_en, set_addr, clr_en, clr_addr and pending[NREG-1:0].
REQ-033 Register storage SHALL be flip-flops with async clear, not inferred RAM.

Verification
REQ-034 Write/read: write r5=0x1234, next cycle read rd_addr1=5 -> rd_data1=0x1234, busy1=0.
REQ-035 Bypass: wr_en=1, wr_addr=7, wr_data=0xBEEF, rd_addr2=7 in the same cycle -> rd_data2=0xBEEF.
REQ-036 r0: write r0=0xFFFF; issue on r0 -> rd_data1(0)=0, busy1=0, no pending bit set.
REQ-037 Hazard: issue r3; next cycle rd_addr1=3 -> stall=1; write-back r3=0x0042 -> busy1=0 that cycle and rd_data1=0x0042.
REQ-038 Collision: pending r4, then in one cycle write r4 and issue r4 -> next cycle busy on r4 = 1.
REQ-039 Reset mid-op: pend r1,r2, write r9=0x5555, drop rst_n between clk edges -> immediately stall=0 and all reads return 0.
